// File: rtl/usb_pkg.sv
// Shared USB constants: default IN packet size and endpoint FSM encodings.
package usb_pkg;

  localparam int EP_MAX_PKT_DEFAULT = 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/usb_byte_ram.sv
// Byte-wide storage for the IN endpoint buffer: one synchronous write port, one async read port.
module usb_byte_ram #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // NOTE: storage is deliberately not reset; only the pointers define which bytes are meaningful.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_in_ep_buffer.sv
// Circular byte buffer for one USB IN endpoint; bytes leave only when the host ACKs the packet.
module usb_in_ep_buffer
  import usb_pkg::*;
#(
  parameter int AW      = 6,
  parameter int MAX_PKT = EP_MAX_PKT_DEFAULT,
  parameter int EP_NUM  = 1
) (
  input  logic          clk48,
  input  logic          rst_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          transaction_active,
  input  logic [3:0]    endpoint,
  input  logic          direction_in,
  input  logic          setup,
  input  logic          data_strobe,
  input  logic          success,
  output logic [7:0]    in_data,
  output logic          in_data_valid,
  output logic [AW:0]   level
);

  localparam int              PW      = AW + 1;
  localparam logic [PW-1:0]   DEPTH_P = PW'(2**AW);
  localparam logic [PW-1:0]   MAX_P   = PW'(MAX_PKT);
  localparam logic [3:0]      EP_P    = 4'(EP_NUM);
  localparam logic [PW-1:0]   ONE_P   = PW'(1);

  logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] spec_ptr_q,   spec_ptr_d;
  logic [PW-1:0] avail_q,      avail_d;
  logic [PW-1:0] pkt_cnt_q,    pkt_cnt_d;
  logic [0:0]    state_q,      state_d;

  logic [PW-1:0] fill;
  logic          wr_fire;
  logic          hit;

  // Space is measured against commit_ptr, so bytes in flight still occupy the buffer.
  assign fill          = wr_ptr_q - commit_ptr_q;
  assign wr_ready      = (fill != DEPTH_P);
  assign wr_fire       = wr_valid & wr_ready;
  assign level         = fill;
  assign hit           = transaction_active & (endpoint == EP_P) & direction_in & ~setup;
  assign in_data_valid = (state_q == ST_ACTIVE) && (pkt_cnt_q != avail_q);

  usb_byte_ram #(.AW(AW)) u_ram (
    .clk   (clk48),
    .we    (wr_fire),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (spec_ptr_q[AW-1:0]),
    .rdata (in_data)
  );

  // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    spec_ptr_d   = spec_ptr_q;
    avail_d      = avail_q;
    pkt_cnt_d    = pkt_cnt_q;
    state_d      = state_q;

    if (wr_fire) wr_ptr_d = wr_ptr_q + ONE_P;

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          state_d    = ST_ACTIVE;
          avail_d    = (fill < MAX_P) ? fill : MAX_P;
          pkt_cnt_d  = '0;
          spec_ptr_d = commit_ptr_q;
        end
      end
      ST_ACTIVE: begin
        if (!transaction_active) begin
          state_d = ST_IDLE;
          if (success) commit_ptr_d = spec_ptr_q;
          else         spec_ptr_d   = commit_ptr_q;
        end else if (data_strobe && in_data_valid) begin
          spec_ptr_d = spec_ptr_q + ONE_P;
          pkt_cnt_d  = pkt_cnt_q + ONE_P;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      spec_ptr_q   <= '0;
      avail_q      <= '0;
      pkt_cnt_q    <= '0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      spec_ptr_q   <= spec_ptr_d;
      avail_q      <= avail_d;
      pkt_cnt_q    <= pkt_cnt_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Scoreboard bench for usb_in_ep_buffer: a byte-queue model predicts every served byte and level.
`timescale 1ns/100ps
module tb_usb_in_ep_buffer;

  localparam int AW      = 6;
  localparam int DEPTH   = 2**AW;
  localparam int MAX_PKT = 8;
  localparam int EP_NUM  = 1;

  logic          clk48 = 1'b0;
  logic          rst_n;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          transaction_active;
  logic [3:0]    endpoint;
  logic          direction_in;
  logic          setup;
  logic          data_strobe;
  logic          success;
  logic [7:0]    in_data;
  logic          in_data_valid;
  logic [AW:0]   level;

  usb_in_ep_buffer #(.AW(AW), .MAX_PKT(MAX_PKT), .EP_NUM(EP_NUM)) dut (
    .clk48              (clk48),
    .rst_n              (rst_n),
    .wr_data            (wr_data),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .transaction_active (transaction_active),
    .endpoint           (endpoint),
    .direction_in       (direction_in),
    .setup              (setup),
    .data_strobe        (data_strobe),
    .success            (success),
    .in_data            (in_data),
    .in_data_valid      (in_data_valid),
    .level              (level)
  );

  always #1 clk48 = ~clk48;

  typedef struct {
    bit         valid;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_q[$];   // bytes held between commit and write pointer, oldest first
  bit         m_active;
  int         m_avail;
  int         m_sent;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] wr_cnt = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe the DUT sees is matched against the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk48);
      if (rst_n && data_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected: no expectation queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("in_data_valid", 32'(in_data_valid), 32'(e.valid));
          if (e.valid) check("in_data", 32'(in_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // One clock cycle of stimulus; the model advances by the same cycle's rules.
  task automatic drive(input bit wv, input logic [7:0] wd, input bit ta, input logic [3:0] ep,
                       input bit din, input bit stp, input bit strobe, input bit succ);
    int  pre_size;
    bit  accept;
    bit  is_hit;
    exp_t e;
    @(posedge clk48);
    #0.2;
    wr_valid = wv; wr_data = wd; transaction_active = ta; endpoint = ep;
    direction_in = din; setup = stp; data_strobe = strobe; success = succ;

    pre_size = model_q.size();
    accept   = wv && (pre_size < DEPTH);
    is_hit   = ta && (ep == 4'(EP_NUM)) && din && !stp;
    if (strobe) begin
      e.valid = m_active && ta && (m_sent < m_avail);
      e.data  = e.valid ? model_q[m_sent] : 8'h00;
      if (e.valid) m_sent++;
      exp_q.push_back(e);
    end
    if (!m_active && is_hit) begin
      m_active = 1'b1;
      m_avail  = (pre_size < MAX_PKT) ? pre_size : MAX_PKT;
      m_sent   = 0;
    end else if (m_active && !ta) begin
      if (succ) repeat (m_sent) void'(model_q.pop_front());
      m_active = 1'b0;
    end
    if (accept) model_q.push_back(wd);

    @(negedge clk48);
    if (wv) check("wr_ready", 32'(wr_ready), 32'(pre_size < DEPTH));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 8'h00, 0, 4'(EP_NUM), 1, 0, 0, 0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    drive(1, b, 0, 4'(EP_NUM), 1, 0, 0, 0);
  endtask

  task automatic check_level(input string tag);
    check({tag, "_level"}, 32'(level), 32'(model_q.size()));
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'(model_q.size() != DEPTH));
    check({tag, "_idle_valid"}, 32'(in_data_valid), 32'd0);
  endtask

  // Entry cycle, nstrobe strobes (optionally with producer writes and gaps), then the end cycle.
  task automatic txn(input logic [3:0] ep, input bit din, input bit stp, input int nstrobe,
                     input bit succ, input bit mid_wr, input bit gaps, input string tag);
    drive(0, 8'h00, 1, ep, din, stp, 0, 0);
    for (int i = 0; i < nstrobe; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) drive(0, 8'h00, 1, ep, din, stp, 0, 0);
      drive(mid_wr, wr_cnt, 1, ep, din, stp, 1, 0);
      if (mid_wr) wr_cnt++;
    end
    drive(0, 8'h00, 0, ep, din, stp, 0, succ);
    idle(1);
    check_level(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 0; wr_data = 0; transaction_active = 0; endpoint = 0;
    direction_in = 0; setup = 0; data_strobe = 0; success = 0;
    m_active = 0; m_avail = 0; m_sent = 0;
    #5;
    check("reset_level", 32'(level), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_valid", 32'(in_data_valid), 32'd0);
    @(posedge clk48); #0.2; rst_n = 1'b1;

    // Empty buffer: zero-length packet.
    txn(4'(EP_NUM), 1, 0, 3, 1, 0, 0, "zlp");

    // Ten bytes split into a full packet and a short one.
    for (int i = 0; i < 10; i++) write_byte(8'h11 + 8'(i));
    txn(4'(EP_NUM), 1, 0, 10, 1, 0, 0, "pkt8");
    txn(4'(EP_NUM), 1, 0, 3, 1, 0, 0, "pkt2");

    // NAKed packet is replayed, then committed.
    for (int i = 0; i < 3; i++) write_byte(8'hA0 + 8'(i));
    txn(4'(EP_NUM), 1, 0, 3, 0, 0, 0, "fail");
    txn(4'(EP_NUM), 1, 0, 4, 1, 0, 0, "retry");

    // Fill to full (65th byte refused), then drain across the pointer wrap.
    for (int i = 0; i < DEPTH + 1; i++) write_byte(8'(i * 3 + 1));
    txn(4'(EP_NUM), 1, 0, 8, 1, 0, 0, "full");
    for (int p = 0; p < 7; p++) txn(4'(EP_NUM), 1, 0, 9, 1, 0, 1, "wrap");

    // Bytes written mid-packet wait for the next packet.
    write_byte(8'h55); write_byte(8'h66);
    txn(4'(EP_NUM), 1, 0, 5, 1, 1, 0, "midwr");
    txn(4'(EP_NUM), 1, 0, 6, 1, 0, 0, "midwr_drain");

    // Transactions that are not ours leave everything alone.
    for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
    txn(4'd2, 1, 0, 3, 1, 0, 0, "other_ep");
    txn(4'(EP_NUM), 1, 1, 3, 1, 0, 0, "setup");
    txn(4'(EP_NUM), 0, 0, 3, 1, 0, 0, "out");

    // Reset in the middle of an IN discards everything.
    drive(0, 8'h00, 1, 4'(EP_NUM), 1, 0, 0, 0);
    drive(0, 8'h00, 1, 4'(EP_NUM), 1, 0, 1, 0);
    @(posedge clk48); #0.2;
    rst_n = 1'b0; transaction_active = 0; data_strobe = 0;
    model_q.delete(); m_active = 0;
    @(negedge clk48);
    check("rst_mid_level", 32'(level), 32'd0);
    check("rst_mid_valid", 32'(in_data_valid), 32'd0);
    check("rst_mid_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk48); #0.2; rst_n = 1'b1;
    txn(4'(EP_NUM), 1, 0, 2, 1, 0, 0, "post_rst_zlp");

    // Randomized mix of writes and transactions.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) < 4) begin
        repeat ($urandom_range(1, 12)) begin
          write_byte(wr_cnt);
          wr_cnt++;
        end
      end else begin
        txn(($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'(EP_NUM),
            $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 10), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, 1, "rand");
      end
    end

    idle(2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
